// File: rtl/idma_byte_lane_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : idma_byte_lane_buffer_if
// Brief   : Push/pop bundle for the per-byte-lane elastic buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface idma_byte_lane_buffer_if #(
    parameter int StrbWidth = 16
);
    logic                          clear_i;
    logic [StrbWidth-1:0][7:0]     data_i;
    logic [StrbWidth-1:0]          valid_i;
    logic [StrbWidth-1:0]          ready_o;
    logic [StrbWidth-1:0][7:0]     data_o;
    logic [StrbWidth-1:0]          valid_o;
    logic [StrbWidth-1:0]          ready_i;
    logic                          empty_o;
    logic                          full_o;

    // The buffer itself
    modport slave (
        input  clear_i, data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, empty_o, full_o
    );

    // The read/write backends surrounding the buffer
    modport master (
        output clear_i, data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, empty_o, full_o
    );
endinterface
`default_nettype wire

// File: rtl/idma_byte_lane_buffer.sv
`default_nettype none
// ============================================================================
// Module  : idma_byte_lane_buffer
// Brief   : Independent per-byte-lane FIFOs between the read and write backends.
// Revision: 1.0 - initial release
// ============================================================================
module idma_byte_lane_buffer #(
    parameter int StrbWidth   = 16,
    parameter int BufferDepth = 3
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    idma_byte_lane_buffer_if.slave     bus
);
    typedef logic [7:0]           byte_t;
    typedef logic [StrbWidth-1:0] strb_t;

    localparam int CW = $clog2(BufferDepth + 1);
    localparam int PW = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;

    strb_t w_ready;
    strb_t w_valid;

    for (genvar i = 0; i < StrbWidth; i++) begin : g_lane
        localparam logic [CW-1:0] c_depth    = CW'(BufferDepth);
        localparam logic [PW-1:0] c_last_ptr = PW'(BufferDepth - 1);

        byte_t         r_mem [BufferDepth];
        logic [PW-1:0] r_wptr;
        logic [PW-1:0] r_rptr;
        logic [CW-1:0] r_count;
        logic          w_push;
        logic          w_pop;

        // Handshakes derive from count only, so no comb path crosses the buffer
        assign w_ready[i] = (r_count != c_depth);
        assign w_valid[i] = (r_count != '0);
        assign w_push     = bus.valid_i[i] & w_ready[i];
        assign w_pop      = bus.ready_i[i] & w_valid[i];

        assign bus.data_o[i] = r_mem[r_rptr];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                for (int k = 0; k < BufferDepth; k++) begin
                    r_mem[k] <= '0;
                end
            end else if (bus.clear_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wptr] <= bus.data_i[i];
                    // Depth may be non-power-of-two, so wrap by compare
                    r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

`ifndef SYNTHESIS
        a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
            r_count <= c_depth);
        a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
            !(w_push && (r_count == c_depth)));
        a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
            !(w_pop && (r_count == '0)));
`endif
    end

    assign bus.ready_o = w_ready;
    assign bus.valid_o = w_valid;
    assign bus.empty_o = ~|w_valid;
    assign bus.full_o  = ~&w_ready;

endmodule
`default_nettype wire

// File: tb/tb_idma_byte_lane_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_idma_byte_lane_buffer
// Brief   : Directed self-checking bench for idma_byte_lane_buffer (16 lanes, depth 3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_idma_byte_lane_buffer;
    localparam int c_lanes = 16;
    localparam int c_depth = 3;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    idma_byte_lane_buffer_if #(.StrbWidth(c_lanes)) bus ();

    idma_byte_lane_buffer #(
        .StrbWidth   (c_lanes),
        .BufferDepth (c_depth)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear_i = 1'b0;
        bus.valid_i = '0;
        bus.ready_i = '0;
        bus.data_i  = '0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        idle_inputs();

        // 1. reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 128'(bus.valid_o), 128'h0000);
        check_eq("rst_ready", 128'(bus.ready_o), 128'hFFFF);
        check_eq("rst_empty", 128'(bus.empty_o), 128'h1);
        check_eq("rst_full",  128'(bus.full_o),  128'h0);
        check_eq("rst_data",  128'(bus.data_o),  128'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick();
        check_eq("idle_valid", 128'(bus.valid_o), 128'h0000);
        check_eq("idle_ready", 128'(bus.ready_o), 128'hFFFF);
        check_eq("idle_empty", 128'(bus.empty_o), 128'h1);

        // 2. single push/pop latency
        bus.valid_i   = 16'h00F0;
        bus.data_i[4] = 8'hA4;
        bus.data_i[5] = 8'hA5;
        bus.data_i[6] = 8'hA6;
        bus.data_i[7] = 8'hA7;
        #1;
        check_eq("no_fallthru", 128'(bus.valid_o), 128'h0000);
        tick();
        idle_inputs();
        check_eq("lat_valid", 128'(bus.valid_o), 128'h00F0);
        check_eq("lat_d4",    128'(bus.data_o[4]), 128'hA4);
        check_eq("lat_d7",    128'(bus.data_o[7]), 128'hA7);
        check_eq("lat_empty", 128'(bus.empty_o), 128'h0);
        bus.ready_i = 16'h00F0;
        tick();
        idle_inputs();
        check_eq("pop_valid", 128'(bus.valid_o), 128'h0000);
        check_eq("pop_empty", 128'(bus.empty_o), 128'h1);

        // 3. fill lane 0 and backpressure
        bus.valid_i = 16'h0001;
        bus.data_i[0] = 8'h11; tick();
        bus.data_i[0] = 8'h22; tick();
        bus.data_i[0] = 8'h33; tick();
        check_eq("fill_ready", 128'(bus.ready_o), 128'hFFFE);
        check_eq("fill_full",  128'(bus.full_o),  128'h1);
        check_eq("fill_head",  128'(bus.data_o[0]), 128'h11);
        bus.data_i[0] = 8'h44;
        tick();
        check_eq("held_ready", 128'(bus.ready_o[0]), 128'h0);
        check_eq("held_head",  128'(bus.data_o[0]), 128'h11);
        bus.ready_i = 16'h0001;
        tick();
        check_eq("pop1_head",  128'(bus.data_o[0]), 128'h22);
        check_eq("pop1_ready", 128'(bus.ready_o[0]), 128'h1);
        check_eq("pop1_full",  128'(bus.full_o), 128'h0);
        bus.ready_i = 16'h0000;
        tick();
        check_eq("acc44_full", 128'(bus.full_o), 128'h1);
        bus.valid_i = 16'h0000;
        bus.ready_i = 16'h0001;
        tick();
        check_eq("drain_33", 128'(bus.data_o[0]), 128'h33);
        tick();
        check_eq("drain_44", 128'(bus.data_o[0]), 128'h44);
        tick();
        check_eq("drain_empty", 128'(bus.valid_o), 128'h0000);
        idle_inputs();

        // 4. lane 3 full with simultaneous push/pop, then streaming
        bus.valid_i = 16'h0008;
        bus.data_i[3] = 8'h30; tick();
        bus.data_i[3] = 8'h31; tick();
        bus.data_i[3] = 8'h32; tick();
        bus.data_i[3] = 8'h33;
        bus.ready_i = 16'h0008;
        check_eq("l3_full_ready", 128'(bus.ready_o[3]), 128'h0);
        check_eq("l3_head30", 128'(bus.data_o[3]), 128'h30);
        tick();
        check_eq("l3_head31",  128'(bus.data_o[3]), 128'h31);
        check_eq("l3_ready",   128'(bus.ready_o[3]), 128'h1);
        check_eq("l3_notfull", 128'(bus.full_o), 128'h0);
        tick();
        check_eq("l3_head32", 128'(bus.data_o[3]), 128'h32);
        bus.data_i[3] = 8'h34; tick();
        check_eq("l3_head33", 128'(bus.data_o[3]), 128'h33);
        bus.data_i[3] = 8'h35; tick();
        check_eq("l3_head34", 128'(bus.data_o[3]), 128'h34);
        check_eq("l3_stream_ready", 128'(bus.ready_o[3]), 128'h1);
        bus.valid_i = 16'h0000;
        tick();
        check_eq("l3_head35", 128'(bus.data_o[3]), 128'h35);
        tick();
        check_eq("l3_empty", 128'(bus.empty_o), 128'h1);
        idle_inputs();

        // 5. stream through lane 0 across pointer wraps, lane 15 idle
        bus.ready_i = 16'h0001;
        bus.valid_i = 16'h0001;
        for (int j = 0; j < 10; j++) begin
            bus.data_i[0] = 8'(j);
            tick();
            check_eq($sformatf("wrap_head%0d", j), 128'(bus.data_o[0]), 128'(j));
        end
        check_eq("wrap_l15", 128'(bus.valid_o[15]), 128'h0);
        check_eq("wrap_notempty", 128'(bus.empty_o), 128'h0);
        bus.valid_i = 16'h0000;
        tick();
        check_eq("wrap_drained", 128'(bus.valid_o), 128'h0000);
        idle_inputs();

        // 6a. clear with concurrent push on lane 8
        bus.valid_i = 16'h00FF;
        bus.data_i  = {c_lanes{8'h5A}};
        tick();
        tick();
        check_eq("pre_clr_valid", 128'(bus.valid_o), 128'h00FF);
        check_eq("pre_clr_ready", 128'(bus.ready_o), 128'hFFFF);
        bus.clear_i   = 1'b1;
        bus.valid_i   = 16'h0100;
        bus.ready_i   = 16'h00FF;
        bus.data_i[8] = 8'h88;
        tick();
        idle_inputs();
        check_eq("clr_valid", 128'(bus.valid_o), 128'h0000);
        check_eq("clr_empty", 128'(bus.empty_o), 128'h1);
        tick();
        check_eq("clr_drop8", 128'(bus.valid_o), 128'h0000);

        // 6b. asynchronous reset mid-cycle
        bus.valid_i = 16'h00FF;
        bus.data_i  = {c_lanes{8'h5A}};
        tick();
        idle_inputs();
        check_eq("pre_rst_valid", 128'(bus.valid_o), 128'h00FF);
        check_eq("pre_rst_data",  128'(bus.data_o[0]), 128'h5A);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", 128'(bus.valid_o), 128'h0000);
        check_eq("arst_ready", 128'(bus.ready_o), 128'hFFFF);
        check_eq("arst_data",  128'(bus.data_o),  128'h0);
        check_eq("arst_empty", 128'(bus.empty_o), 128'h1);
        check_eq("arst_full",  128'(bus.full_o),  128'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("post_rst_valid", 128'(bus.valid_o), 128'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
